// File: rtl/cpu_cmp_pkg.sv
// Shared types for the 6502 lockstep comparator: FSM states, error codes
// and the packed bus transaction layout {addr, data, rw}.
package cpu_cmp_pkg;

    localparam int TXN_AW = 16;
    localparam int TXN_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_e;

    // Packed so that a bus_txn_t is bit-identical to {addr, data, rw}.
    typedef struct packed {
        logic [TXN_AW-1:0] addr;
        logic [TXN_DW-1:0] data;
        logic              rw;
    } bus_txn_t;

endpackage

// File: rtl/lockstep_fifo.sv
// Per-side transaction FIFO. Pointers carry one extra MSB so full and
// empty can be told apart when the index bits are equal. The head entry is
// presented combinationally; the consumer registers it on pop.
module lockstep_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr_reg;
    logic [PW:0]  rd_ptr_reg;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                     (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees a slot.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg[PW-1:0]];

    // Storage write; no reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg[PW-1:0]] <= din;
        end
    end

    // Pointer update; flush empties the FIFO and wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_lockstep_cmp.sv
// Lockstep checker between the DUV and reference 6502 bus streams. Each
// side is buffered in its own FIFO; heads are popped together, registered,
// and compared one cycle later. The first mismatch/overflow/timeout is
// latched with context.
module cpu_lockstep_cmp
    import cpu_cmp_pkg::*;
#(
    parameter int AW          = TXN_AW,
    parameter int DW          = TXN_DW,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT     = 64,
    parameter int CW          = 32,
    parameter int STOP_ON_ERR = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   duv_valid,
    input  logic [AW-1:0]          duv_addr,
    input  logic [DW-1:0]          duv_data,
    input  logic                   duv_rw,
    input  logic                   ref_valid,
    input  logic [AW-1:0]          ref_addr,
    input  logic [DW-1:0]          ref_data,
    input  logic                   ref_rw,
    output logic [CW-1:0]          match_cnt,
    output logic                   err,
    output logic [1:0]             err_code,
    output logic [CW-1:0]          err_index,
    output logic [AW+DW:0]         err_duv,
    output logic [AW+DW:0]         err_ref,
    output logic [$clog2(DEPTH):0] duv_level,
    output logic [$clog2(DEPTH):0] ref_level
);

    localparam int  TW   = AW + DW + 1;
    localparam int  LW   = $clog2(DEPTH) + 1;
    localparam int  SW   = $clog2(TIMEOUT + 1);
    localparam bit  STOP = (STOP_ON_ERR != 0);

    state_e             state_reg;
    logic               active;
    logic               pop;
    logic [1:0]         side_push;
    logic [1:0]         side_full;
    logic [1:0]         side_empty;
    logic [1:0][TW-1:0] side_din;
    logic [1:0][TW-1:0] side_dout;
    logic [1:0][LW-1:0] side_level;

    logic               cmp_valid_reg;
    logic [TW-1:0]      cmp_duv_reg;
    logic [TW-1:0]      cmp_ref_reg;
    logic [SW-1:0]      skew_reg;
    logic [CW-1:0]      match_cnt_reg;
    logic               err_reg;
    err_e               err_code_reg;
    logic [CW-1:0]      err_index_reg;
    logic [TW-1:0]      err_duv_reg;
    logic [TW-1:0]      err_ref_reg;

    logic               evaluating;
    logic               cmp_mismatch;
    logic               cmp_match;
    logic               ovf;
    logic               one_nonempty;
    logic               tmo;
    err_e               err_kind;
    logic               err_hit;

    // Side 0 is the DUV, side 1 the reference.
    assign active      = enable && (state_reg == RUN);
    assign side_push   = {ref_valid, duv_valid} & {2{active}};
    assign side_din[0] = {duv_addr, duv_data, duv_rw};
    assign side_din[1] = {ref_addr, ref_data, ref_rw};
    assign pop         = active && (side_empty == 2'b00);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            lockstep_fifo #(
                .W     (TW),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .flush (clear),
                .push  (side_push[gi]),
                .pop   (pop),
                .din   (side_din[gi]),
                .dout  (side_dout[gi]),
                .full  (side_full[gi]),
                .empty (side_empty[gi]),
                .level (side_level[gi])
            );
        end
    endgenerate

    // The registered pair is still judged after enable drops, but never in HALT.
    assign evaluating   = cmp_valid_reg && (state_reg != HALT);
    assign cmp_mismatch = evaluating && (cmp_duv_reg != cmp_ref_reg);
    assign cmp_match    = evaluating && (cmp_duv_reg == cmp_ref_reg);
    assign ovf          = (|(side_push & side_full)) && !pop;
    assign one_nonempty = ^side_empty;
    assign tmo          = active && one_nonempty && (skew_reg == SW'(TIMEOUT - 1));

    // Error classification with mismatch > overflow > timeout priority.
    always_comb begin
        err_kind = ERR_NONE;
        if (cmp_mismatch)      err_kind = ERR_MISMATCH;
        else if (ovf)          err_kind = ERR_OVERFLOW;
        else if (tmo)          err_kind = ERR_TIMEOUT;
    end

    assign err_hit = !err_reg && (err_kind != ERR_NONE);

    // Run-control FSM; HALT is left only through clear or rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else if (clear) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (err_hit && STOP) state_reg <= HALT;
                         else if (enable)     state_reg <= RUN;
                RUN:     if (err_hit && STOP) state_reg <= HALT;
                         else if (!enable)    state_reg <= IDLE;
                default: state_reg <= HALT;
            endcase
        end
    end

    // Compare stage: capture both FIFO heads on a joint pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_valid_reg <= 1'b0;
            cmp_duv_reg   <= '0;
            cmp_ref_reg   <= '0;
        end else if (clear) begin
            cmp_valid_reg <= 1'b0;
            cmp_duv_reg   <= '0;
            cmp_ref_reg   <= '0;
        end else begin
            cmp_valid_reg <= pop;
            if (pop) begin
                cmp_duv_reg <= side_dout[0];
                cmp_ref_reg <= side_dout[1];
            end
        end
    end

    // Skew counter: counts cycles where only one side holds entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skew_reg <= '0;
        end else if (clear) begin
            skew_reg <= '0;
        end else if (active) begin
            if (!one_nonempty)                   skew_reg <= '0;
            else if (skew_reg != SW'(TIMEOUT))   skew_reg <= skew_reg + 1'b1;
        end
    end

    // Saturating match counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt_reg <= '0;
        end else if (clear) begin
            match_cnt_reg <= '0;
        end else if (cmp_match && (match_cnt_reg != {CW{1'b1}})) begin
            match_cnt_reg <= match_cnt_reg + 1'b1;
        end
    end

    // First-error capture; later errors never overwrite it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
            err_index_reg <= '0;
            err_duv_reg   <= '0;
            err_ref_reg   <= '0;
        end else if (clear) begin
            err_reg       <= 1'b0;
            err_code_reg  <= ERR_NONE;
            err_index_reg <= '0;
            err_duv_reg   <= '0;
            err_ref_reg   <= '0;
        end else if (err_hit) begin
            err_reg       <= 1'b1;
            err_code_reg  <= err_kind;
            err_index_reg <= match_cnt_reg;
            if (err_kind == ERR_MISMATCH) begin
                err_duv_reg <= cmp_duv_reg;
                err_ref_reg <= cmp_ref_reg;
            end
        end
    end

    assign match_cnt = match_cnt_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;
    assign err_index = err_index_reg;
    assign err_duv   = err_duv_reg;
    assign err_ref   = err_ref_reg;
    assign duv_level = side_level[0];
    assign ref_level = side_level[1];

endmodule

// File: tb/tb_cpu_lockstep_cmp.sv
// Directed/randomized bench for cpu_lockstep_cmp. Expected values come from
// per-side transaction queues: the expected match count is the number of
// leading pairs that agree, and error cases use the documented limits.
module tb_cpu_lockstep_cmp;
    import cpu_cmp_pkg::*;

    localparam int AW      = 16;
    localparam int DW      = 8;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int CW      = 32;
    localparam int TW      = AW + DW + 1;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          clear;
    logic          duv_valid;
    logic [AW-1:0] duv_addr;
    logic [DW-1:0] duv_data;
    logic          duv_rw;
    logic          ref_valid;
    logic [AW-1:0] ref_addr;
    logic [DW-1:0] ref_data;
    logic          ref_rw;
    logic [CW-1:0] match_cnt;
    logic          err;
    logic [1:0]    err_code;
    logic [CW-1:0] err_index;
    logic [TW-1:0] err_duv;
    logic [TW-1:0] err_ref;
    logic [LW-1:0] duv_level;
    logic [LW-1:0] ref_level;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int max_duv   = 0;

    bus_txn_t dq[$];
    bus_txn_t rq[$];
    bus_txn_t t;
    bus_txn_t u;
    bus_txn_t none;

    cpu_lockstep_cmp #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(CW), .STOP_ON_ERR(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .duv_valid(duv_valid), .duv_addr(duv_addr), .duv_data(duv_data), .duv_rw(duv_rw),
        .ref_valid(ref_valid), .ref_addr(ref_addr), .ref_data(ref_data), .ref_rw(ref_rw),
        .match_cnt(match_cnt), .err(err), .err_code(err_code), .err_index(err_index),
        .err_duv(err_duv), .err_ref(err_ref), .duv_level(duv_level), .ref_level(ref_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (int'(duv_level) > max_duv) max_duv = int'(duv_level);
    endtask

    task automatic drive(input logic dv, input bus_txn_t dt, input logic rv, input bus_txn_t rt);
        duv_valid = dv; duv_addr = dt.addr; duv_data = dt.data; duv_rw = dt.rw;
        ref_valid = rv; ref_addr = rt.addr; ref_data = rt.data; ref_rw = rt.rw;
        tick();
    endtask

    task automatic go_idle();
        duv_valid = 1'b0;
        ref_valid = 1'b0;
    endtask

    // Clear, then one cycle for the comparator to re-enter RUN.
    task automatic do_clear();
        go_idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        max_duv = 0;
        dq.delete();
        rq.delete();
    endtask

    function automatic bus_txn_t rand_txn();
        bus_txn_t r;
        r.addr = 16'($urandom);
        r.data = 8'($urandom);
        r.rw   = 1'($urandom);
        return r;
    endfunction

    // Number of leading transaction pairs that agree.
    function automatic int exp_matches();
        int n = 0;
        for (int i = 0; i < dq.size() && i < rq.size(); i++) begin
            if (dq[i] != rq[i]) break;
            n++;
        end
        return n;
    endfunction

    initial begin
        none = '0;
        rst = 1'b1; enable = 1'b0; clear = 1'b0;
        go_idle();
        duv_addr = '0; duv_data = '0; duv_rw = 1'b0;
        ref_addr = '0; ref_data = '0; ref_rw = 1'b0;
        repeat (2) tick();
        check("reset_match_cnt", 64'(match_cnt), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_err_code", 64'(err_code), 64'd0);
        check("reset_duv_level", 64'(duv_level), 64'd0);
        rst = 1'b0;
        enable = 1'b1;
        tick();

        // Identical 100-transaction stream, one pair per cycle.
        for (int i = 0; i < 100; i++) begin
            t = rand_txn();
            dq.push_back(t);
            rq.push_back(t);
            drive(1'b1, t, 1'b1, t);
        end
        go_idle();
        tick();
        check("t1_cnt_1clk", 64'(match_cnt), 64'(exp_matches() - 1));
        tick();
        check("t1_cnt_2clk", 64'(match_cnt), 64'(exp_matches()));
        check("t1_err", 64'(err), 64'd0);
        check("t1_levels", 64'({duv_level, ref_level}), 64'd0);
        $display("txn t1: match_cnt=%0d err=%0d", match_cnt, err);

        // DUV leads by 5, reference catches up, then both stream together.
        do_clear();
        for (int i = 0; i < 20; i++) begin
            t = rand_txn();
            dq.push_back(t);
            rq.push_back(t);
        end
        for (int i = 0; i < 5; i++) drive(1'b1, dq[i], 1'b0, none);
        check("t2_peak_duv", 64'(duv_level), 64'd5);
        check("t2_peak_ref", 64'(ref_level), 64'd0);
        for (int i = 0; i < 5; i++) drive(1'b0, none, 1'b1, rq[i]);
        for (int i = 5; i < 20; i++) drive(1'b1, dq[i], 1'b1, rq[i]);
        go_idle();
        repeat (3) tick();
        check("t2_match_cnt", 64'(match_cnt), 64'(exp_matches()));
        check("t2_err", 64'(err), 64'd0);
        check("t2_max_duv", 64'(max_duv), 64'd5);
        $display("txn t2: match_cnt=%0d max_duv_level=%0d", match_cnt, max_duv);

        // Divergence on transaction #7 (data A9 vs A5).
        do_clear();
        for (int i = 0; i < 12; i++) begin
            t = rand_txn();
            u = t;
            if (i == 7) begin
                t.data = 8'hA9;
                u.data = 8'hA5;
            end
            dq.push_back(t);
            rq.push_back(u);
            drive(1'b1, t, 1'b1, u);
        end
        go_idle();
        repeat (3) tick();
        check("t3_err", 64'(err), 64'd1);
        check("t3_err_code", 64'(err_code), 64'(ERR_MISMATCH));
        check("t3_err_index", 64'(err_index), 64'(exp_matches()));
        check("t3_err_duv", 64'(err_duv), 64'(dq[7]));
        check("t3_err_ref", 64'(err_ref), 64'(rq[7]));
        check("t3_match_cnt", 64'(match_cnt), 64'(exp_matches()));
        $display("txn t3: err_code=%0d err_index=%0d duv=%0h ref=%0h", err_code, err_index, err_duv, err_ref);

        // Overflow: 9 DUV pushes into an 8-deep FIFO with the reference idle.
        do_clear();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, rand_txn(), 1'b0, none);
        check("t4_full_level", 64'(duv_level), 64'(DEPTH));
        check("t4_no_err_yet", 64'(err), 64'd0);
        drive(1'b1, rand_txn(), 1'b0, none);
        go_idle();
        check("t4_err_code", 64'(err_code), 64'(ERR_OVERFLOW));
        check("t4_level_after", 64'(duv_level), 64'(DEPTH));
        $display("txn t4: err_code=%0d duv_level=%0d", err_code, duv_level);

        // Timeout: one DUV entry, reference silent.
        do_clear();
        drive(1'b1, rand_txn(), 1'b0, none);
        go_idle();
        repeat (TIMEOUT - 1) tick();
        check("t5_no_err_63", 64'(err_code), 64'(ERR_NONE));
        tick();
        check("t5_err_code_64", 64'(err_code), 64'(ERR_TIMEOUT));
        check("t5_err_index", 64'(err_index), 64'd0);
        $display("txn t5: err_code=%0d after %0d cycles", err_code, TIMEOUT);

        // Clear after an error, then reset mid-stream, then a clean stream.
        go_idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t6_clear_err", 64'(err), 64'd0);
        check("t6_clear_code", 64'(err_code), 64'd0);
        check("t6_clear_levels", 64'({duv_level, ref_level}), 64'd0);
        tick();
        dq.delete();
        rq.delete();
        for (int i = 0; i < 5; i++) begin
            t = rand_txn();
            dq.push_back(t);
            rq.push_back(t);
            drive(1'b1, t, 1'b1, t);
        end
        go_idle();
        repeat (2) tick();
        check("t6_pre_rst_cnt", 64'(match_cnt), 64'(exp_matches()));
        for (int i = 0; i < 3; i++) begin
            t = rand_txn();
            drive(1'b1, t, 1'b1, t);
        end
        go_idle();
        rst = 1'b1;
        #1;
        check("t6_rst_cnt", 64'(match_cnt), 64'd0);
        check("t6_rst_levels", 64'({duv_level, ref_level}), 64'd0);
        check("t6_rst_err", 64'(err), 64'd0);
        #1;
        rst = 1'b0;
        tick();
        dq.delete();
        rq.delete();
        for (int i = 0; i < 10; i++) begin
            t = rand_txn();
            dq.push_back(t);
            rq.push_back(t);
            drive(1'b1, t, 1'b1, t);
        end
        go_idle();
        repeat (3) tick();
        check("t6_fresh_cnt", 64'(match_cnt), 64'(exp_matches()));
        check("t6_fresh_err", 64'(err), 64'd0);
        $display("txn t6: match_cnt=%0d err=%0d", match_cnt, err);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
